// File: rtl/s_machine_sequencer.sv
// S-Machine fetch/decode/execute sequencer.
// Owns the program counter and the single shared memory port. Instruction
// fetch and LD/ST data accesses are serialised through one request/ack
// handshake. Each fetched instruction is handed to the interpreter datapath
// with a one-cycle execute strobe. A stalled memory access ends in a sticky
// FAULT state that only reset can clear.
module s_machine_sequencer #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_val,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] st_data,
  output logic [DATA_W-1:0] inst_out,
  output logic [DATA_W-1:0] ld_data,
  output logic              exec_en,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              fault,
  output logic [15:0]       retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_MEM    = 3'd3,
    S_EXEC   = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] PC_ONE    = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [7:0]        TIMEOUT_C = 8'(TIMEOUT);

  state_t            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [DATA_W-1:0] inst_q;
  logic [DATA_W-1:0] ld_data_q;
  logic [15:0]       retired_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              exec_en_q;
  logic              fault_q;
  logic [7:0]        wait_q;
  logic [7:0]        wait_d;

  logic [3:0] op;
  logic       is_ld;
  logic       is_st;

  // Opcode classification of the held instruction and the wait-counter increment.
  always_comb begin
    op     = inst_q[15:12];
    is_ld  = (op == 4'b0000) && !inst_q[10];
    is_st  = (op == 4'b0001);
    wait_d = wait_q + 8'd1;
  end

  // Sequencer FSM; every port-facing signal is a register updated here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      inst_q      <= '0;
      ld_data_q   <= '0;
      retired_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      exec_en_q   <= 1'b0;
      fault_q     <= 1'b0;
      wait_q      <= '0;
    end else begin
      // The execute strobe is only ever raised on the transition into EXEC.
      exec_en_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pc_load) begin
            pc_q <= pc_load_val;
          end else if (run) begin
            state_q    <= S_FETCH;
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= pc_q;
            wait_q     <= '0;
          end
        end

        S_FETCH: begin
          if (mem_ack) begin
            inst_q    <= mem_rdata;
            pc_q      <= pc_q + PC_ONE;
            mem_req_q <= 1'b0;
            state_q   <= S_DECODE;
          end else if (wait_d == TIMEOUT_C) begin
            // pc is left pointing at the fetch that never completed.
            mem_req_q <= 1'b0;
            fault_q   <= 1'b1;
            state_q   <= S_FAULT;
          end else begin
            wait_q <= wait_d;
          end
        end

        S_DECODE: begin
          if (is_ld || is_st) begin
            // Address, direction and store data are frozen for the whole access.
            state_q     <= S_MEM;
            mem_req_q   <= 1'b1;
            mem_we_q    <= is_st;
            mem_addr_q  <= inst_q[ADDR_W-1:0];
            mem_wdata_q <= st_data;
            wait_q      <= '0;
          end else begin
            state_q   <= S_EXEC;
            exec_en_q <= 1'b1;
          end
        end

        S_MEM: begin
          if (mem_ack) begin
            if (!mem_we_q) begin
              ld_data_q <= mem_rdata;
            end
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            state_q   <= S_EXEC;
            exec_en_q <= 1'b1;
          end else if (wait_d == TIMEOUT_C) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            fault_q   <= 1'b1;
            state_q   <= S_FAULT;
          end else begin
            wait_q <= wait_d;
          end
        end

        S_EXEC: begin
          retired_q <= retired_q + 16'd1;
          if (run) begin
            state_q    <= S_FETCH;
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= pc_q;
            wait_q     <= '0;
          end else begin
            state_q <= S_IDLE;
          end
        end

        S_FAULT: begin
          state_q <= S_FAULT;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign inst_out  = inst_q;
  assign ld_data   = ld_data_q;
  assign exec_en   = exec_en_q;
  assign pc        = pc_q;
  assign busy      = (state_q != S_IDLE);
  assign fault     = fault_q;
  assign retired   = retired_q;

endmodule

// File: tb/tb_s_machine_sequencer.sv
// Bench for s_machine_sequencer: a behavioural memory with programmable wait
// states, a table of single-instruction vectors, hand sequences for timeout,
// asynchronous reset and run-drop, then a random program checked against an
// instruction-level model of the machine.
`timescale 1ns/1ps
module tb_s_machine_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        pc_load = 1'b0;
  logic [7:0]  pc_load_val = 8'h00;
  logic        mem_req;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = 16'hDEAD;
  logic        mem_ack = 1'b0;
  logic [15:0] st_data = 16'h0000;
  logic [15:0] inst_out;
  logic [15:0] ld_data;
  logic        exec_en;
  logic [7:0]  pc;
  logic        busy;
  logic        fault;
  logic [15:0] retired;

  s_machine_sequencer #(.ADDR_W(8), .DATA_W(16), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .pc_load(pc_load), .pc_load_val(pc_load_val),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .st_data(st_data),
    .inst_out(inst_out), .ld_data(ld_data), .exec_en(exec_en), .pc(pc),
    .busy(busy), .fault(fault), .retired(retired)
  );

  always #5 clk = ~clk;

  // Memory image: bench preloads and DUT stores live in separate arrays;
  // the more recent of the two wins on read.
  logic [15:0]     img   [256];
  longint unsigned img_t [256];
  logic [15:0]     wrd   [256];
  longint unsigned wr_t  [256];

  function automatic logic [15:0] mem_rd(input logic [7:0] a);
    return (wr_t[a] > img_t[a]) ? wrd[a] : img[a];
  endfunction

  task automatic poke(input logic [7:0] a, input logic [15:0] d);
    img[a]   = d;
    img_t[a] = $time;
  endtask

  int fixed_wait = 0;
  bit rand_wait  = 1'b0;
  bit stall      = 1'b0;
  int wcnt = 0, cur_target = 0, tot_waits = 0;
  bit acc_active = 1'b0;

  // Memory responder: ack after cur_target wait cycles, never without a request.
  always @(negedge clk) begin
    if (mem_req && !stall) begin
      if (!acc_active) begin
        acc_active = 1'b1;
        wcnt       = 0;
        cur_target = rand_wait ? int'($urandom_range(0, 3)) : fixed_wait;
      end
      if (wcnt >= cur_target) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_rd(mem_addr);
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = 16'hDEAD;
        wcnt++;
        tot_waits++;
      end
    end else begin
      mem_ack   = 1'b0;
      mem_rdata = 16'hDEAD;
      if (!mem_req) acc_active = 1'b0;
    end
  end

  int          wr_count = 0;
  logic [7:0]  last_waddr = 8'h00;
  logic [15:0] last_wdata = 16'h0000;

  // Store capture on the accepting edge.
  always @(posedge clk) begin
    if (rst_n && mem_req && mem_ack && mem_we) begin
      wrd[mem_addr]  = mem_wdata;
      wr_t[mem_addr] = $time;
      wr_count++;
      last_waddr = mem_addr;
      last_wdata = mem_wdata;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Protocol monitor: request fields frozen during an access, no strobe while accessing.
  logic        p_req = 1'b0;
  logic [7:0]  p_addr = 8'h00;
  logic        p_we = 1'b0;
  logic [15:0] p_wd = 16'h0000;
  int          viol = 0;
  int          exec_count = 0;
  always @(negedge clk) begin
    if (exec_en) exec_count++;
    if (exec_en && mem_req) viol++;
    if (mem_req && p_req && (mem_addr !== p_addr || mem_we !== p_we || mem_wdata !== p_wd)) viol++;
    p_req  = mem_req;
    p_addr = mem_addr;
    p_we   = mem_we;
    p_wd   = mem_wdata;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic wait_exec(output bit got);
    got = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (exec_en) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic [7:0]  pc0;
    logic [15:0] inst;
    logic [7:0]  oa;
    logic [15:0] ov;
    logic [15:0] st;
    int          waits;
    int          lat;
    logic [7:0]  pc1;
    logic [15:0] ld;
    bit          we;
    logic [7:0]  wa;
    logic [15:0] wd;
  } vec_t;

  vec_t tbl [9];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          got;
    int          r, fc, e0, w0, exp_ret, bad, prev_cyc, prev_w, exp_lat;
    logic [15:0] ref_mem [256];
    logic [7:0]  ref_pc;
    logic [15:0] ref_ld, w, ins;
    logic [3:0]  op;
    bit          found, r_ld, r_st;

    for (int a = 0; a < 256; a++) begin
      img[a] = 16'h0000; img_t[a] = 0; wrd[a] = 16'h0000; wr_t[a] = 0;
    end

    //          pc0    inst      oa     ov        st       wt lat pc1    ld        we  wa     wd
    tbl[0] = '{8'h01, 16'h0010, 8'h10, 16'hBEEF, 16'h0000, 0,  4, 8'h02, 16'hBEEF, 0, 8'h00, 16'h0000};
    tbl[1] = '{8'h02, 16'h1820, 8'h20, 16'h0000, 16'h1234, 3, 10, 8'h03, 16'hBEEF, 1, 8'h20, 16'h1234};
    tbl[2] = '{8'hFF, 16'h0C05, 8'hF0, 16'h0000, 16'h0000, 0,  3, 8'h00, 16'hBEEF, 0, 8'h00, 16'h0000};
    tbl[3] = '{8'h30, 16'h3ABC, 8'hF0, 16'h0000, 16'h0000, 1,  4, 8'h31, 16'hBEEF, 0, 8'h00, 16'h0000};
    tbl[4] = '{8'h40, 16'hF000, 8'hF0, 16'h0000, 16'h0000, 0,  3, 8'h41, 16'hBEEF, 0, 8'h00, 16'h0000};
    tbl[5] = '{8'h50, 16'h0455, 8'hF0, 16'h0000, 16'h0000, 2,  5, 8'h51, 16'hBEEF, 0, 8'h00, 16'h0000};
    tbl[6] = '{8'h60, 16'h0877, 8'h77, 16'hCAFE, 16'h0000, 2,  8, 8'h61, 16'hCAFE, 0, 8'h00, 16'h0000};
    tbl[7] = '{8'h70, 16'h1005, 8'h05, 16'h0000, 16'h0F0F, 0,  4, 8'h71, 16'hCAFE, 1, 8'h05, 16'h0F0F};
    tbl[8] = '{8'h80, 16'h4000, 8'hF0, 16'h0000, 16'h0000, 0,  3, 8'h81, 16'hCAFE, 0, 8'h00, 16'h0000};

    // Reset values
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_pc", pc, 8'h00);
    chk("rst_inst", inst_out, 16'h0000);
    chk("rst_ld", ld_data, 16'h0000);
    chk("rst_retired", retired, 16'h0000);
    chk("rst_req", mem_req, 1'b0);
    chk("rst_we", mem_we, 1'b0);
    chk("rst_addr", mem_addr, 8'h00);
    chk("rst_wdata", mem_wdata, 16'h0000);
    chk("rst_exec", exec_en, 1'b0);
    chk("rst_fault", fault, 1'b0);
    chk("rst_busy", busy, 1'b0);

    // First instruction straight out of reset
    poke(8'h00, 16'h4000);
    fixed_wait = 0;
    run = 1'b1;
    r = cyc;
    @(negedge clk);
    chk("c1_req", mem_req, 1'b1);
    chk("c1_addr", mem_addr, 8'h00);
    chk("c1_we", mem_we, 1'b0);
    run = 1'b0;
    wait_exec(got);
    chk("c1_exec_seen", got, 1'b1);
    chk("c1_latency", cyc - r, 3);
    chk("c1_pc", pc, 8'h01);
    chk("c1_inst", inst_out, 16'h4000);
    @(negedge clk);
    chk("c1_retired", retired, 16'h0001);
    chk("c1_busy", busy, 1'b0);
    exp_ret = 1;

    // Single-instruction vectors
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      pc_load     = 1'b1;
      pc_load_val = tbl[i].pc0;
      poke(tbl[i].oa, tbl[i].ov);
      poke(tbl[i].pc0, tbl[i].inst);
      st_data    = tbl[i].st;
      fixed_wait = tbl[i].waits;
      w0 = wr_count;
      @(negedge clk);
      pc_load = 1'b0;
      run = 1'b1;
      r = cyc;
      @(negedge clk);
      run = 1'b0;
      wait_exec(got);
      chk($sformatf("v%0d_exec_seen", i), got, 1'b1);
      chk($sformatf("v%0d_latency", i), cyc - r, tbl[i].lat);
      chk($sformatf("v%0d_inst", i), inst_out, tbl[i].inst);
      chk($sformatf("v%0d_pc", i), pc, tbl[i].pc1);
      chk($sformatf("v%0d_ld", i), ld_data, tbl[i].ld);
      chk($sformatf("v%0d_writes", i), wr_count - w0, tbl[i].we ? 1 : 0);
      if (tbl[i].we) begin
        chk($sformatf("v%0d_waddr", i), last_waddr, tbl[i].wa);
        chk($sformatf("v%0d_wdata", i), last_wdata, tbl[i].wd);
      end
      @(negedge clk);
      exp_ret++;
      chk($sformatf("v%0d_retired", i), retired, exp_ret);
      chk($sformatf("v%0d_busy", i), busy, 1'b0);
    end

    // run dropped while a load is waiting in the data phase
    @(negedge clk);
    pc_load = 1'b1;
    pc_load_val = 8'h06;
    poke(8'h06, 16'h0010);
    poke(8'h10, 16'h5A5A);
    fixed_wait = 3;
    @(negedge clk);
    pc_load = 1'b0;
    run = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (mem_req && mem_addr == 8'h10) begin
        found = 1'b1;
        break;
      end
    end
    chk("rd_mem_phase_seen", found, 1'b1);
    chk("rd_mem_we", mem_we, 1'b0);
    e0 = exec_count;
    run = 1'b0;
    repeat (20) @(negedge clk);
    exp_ret++;
    chk("rd_exec_pulses", exec_count - e0, 1);
    chk("rd_busy", busy, 1'b0);
    chk("rd_ld", ld_data, 16'h5A5A);
    chk("rd_retired", retired, exp_ret);

    // Fetch timeout
    pc_load = 1'b1;
    pc_load_val = 8'h42;
    stall = 1'b1;
    @(negedge clk);
    pc_load = 1'b0;
    run = 1'b1;
    r = cyc;
    fc = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (fault) begin
        fc = cyc;
        break;
      end
    end
    chk("to_fault_cycle", fc - r, 16);
    chk("to_req", mem_req, 1'b0);
    chk("to_pc", pc, 8'h42);
    chk("to_busy", busy, 1'b1);
    e0 = exec_count;
    repeat (5) @(negedge clk);
    chk("to_fault_sticky", fault, 1'b1);
    chk("to_req_sticky", mem_req, 1'b0);
    chk("to_no_exec", exec_count - e0, 0);
    run = 1'b0;
    stall = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("to_rst_fault", fault, 1'b0);
    chk("to_rst_pc", pc, 8'h00);
    chk("to_rst_retired", retired, 16'h0000);

    // Asynchronous reset in the middle of a data access
    @(negedge clk);
    pc_load = 1'b1;
    pc_load_val = 8'h05;
    poke(8'h05, 16'h0810);
    fixed_wait = 5;
    @(negedge clk);
    pc_load = 1'b0;
    run = 1'b1;
    repeat (9) @(negedge clk);
    chk("ar_req_before", mem_req, 1'b1);
    chk("ar_addr_before", mem_addr, 8'h10);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_req_async", mem_req, 1'b0);
    chk("ar_busy_async", busy, 1'b0);
    run = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Random program against an instruction-level model
    for (int a = 0; a < 256; a++) begin
      w = 16'($urandom);
      r = int'($urandom_range(0, 9));
      if (r < 3) w[15:12] = 4'h0;
      else if (r < 5) w[15:12] = 4'h1;
      poke(a[7:0], w);
      ref_mem[a] = w;
    end
    ref_pc = 8'h00;
    ref_ld = 16'h0000;
    exp_ret = 0;
    rand_wait = 1'b1;
    st_data = 16'($urandom);
    run = 1'b1;
    prev_cyc = cyc;
    prev_w = tot_waits;
    for (int n = 0; n < 60; n++) begin
      wait_exec(got);
      chk($sformatf("rnd%0d_exec_seen", n), got, 1'b1);
      if (!got) break;
      ins = ref_mem[ref_pc];
      ref_pc = ref_pc + 8'd1;
      op = ins[15:12];
      r_ld = (op == 4'h0) && !ins[10];
      r_st = (op == 4'h1);
      if (r_ld) ref_ld = ref_mem[ins[7:0]];
      if (r_st) ref_mem[ins[7:0]] = st_data;
      exp_lat = 3 + ((r_ld || r_st) ? 1 : 0) + (tot_waits - prev_w);
      chk($sformatf("rnd%0d_latency", n), cyc - prev_cyc, exp_lat);
      chk($sformatf("rnd%0d_inst", n), inst_out, ins);
      chk($sformatf("rnd%0d_pc", n), pc, ref_pc);
      chk($sformatf("rnd%0d_ld", n), ld_data, ref_ld);
      prev_cyc = cyc;
      prev_w = tot_waits;
      exp_ret++;
      st_data = 16'($urandom);
      if (n == 59) run = 1'b0;
      @(negedge clk);
    end
    chk("rnd_busy_end", busy, 1'b0);
    chk("rnd_retired", retired, exp_ret);
    bad = 0;
    for (int a = 0; a < 256; a++) begin
      if (mem_rd(a[7:0]) !== ref_mem[a]) bad++;
    end
    chk("rnd_memory_image_bad_words", bad, 0);
    chk("handshake_violations", viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/s_machine_sequencer.md
Name: s_machine_sequencer

Overview:
- Fetch/decode/execute controller for the S-Machine CPU.
- Owns the PC and the single shared memory port. Arbitrates that port between instruction fetch and LD/ST data access.
- Presents each fetched instruction to the instruction interpreter with a one-cycle execute strobe.
- Sits between the unified 256x16 memory and the interpreter datapath.

Parameters:
- ADDR_W, 8, memory address / PC width
- DATA_W, 16, memory word and instruction width
- TIMEOUT, 15, max cycles mem_req may wait for mem_ack before FAULT (1..255)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- run  in  1  level; 1 = fetch and execute continuously
- pc_load  in  1  load PC from pc_load_val; honoured only in IDLE
- pc_load_val  in  ADDR_W  PC start value
- mem_req  out  1  memory access request
- mem_we  out  1  1 = write, 0 = read; valid while mem_req=1
- mem_addr  out  ADDR_W  access address
- mem_wdata  out  DATA_W  store data
- mem_rdata  in  DATA_W  read data; valid with mem_ack
- mem_ack  in  1  access complete; sampled only when mem_req=1
- st_data  in  DATA_W  datapath register selected by inst[11] (A/B), for ST
- inst_out  out  DATA_W  current instruction register
- ld_data  out  DATA_W  word returned by the last memory LD
- exec_en  out  1  one-cycle execute strobe to the datapath
- pc  out  ADDR_W  program counter
- busy  out  1  state != IDLE
- fault  out  1  memory timeout occurred; sticky
- retired  out  16  count of executed instructions

Behaviour:
- Reset (async, rst_n=0): state=IDLE; pc=0, inst_out=0, ld_data=0, retired=0; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, exec_en=0, fault=0.
- States: IDLE, FETCH, DECODE, MEM, EXEC, FAULT.
- IDLE:
  - pc_load=1: pc<=pc_load_val. pc_load takes priority over run in the same cycle; stay IDLE.
  - else run=1: go to FETCH.
- FETCH:
  - mem_req=1, mem_we=0, mem_addr=pc.
  - On a clk edge with mem_ack=1: inst_out<=mem_rdata; pc<=pc+1 (255 wraps to 0); go to DECODE.
- DECODE (always 1 cycle):
  - op=inst_out[15:12].
  - Go to MEM if op=0000 with inst_out[10]=0 (memory LD), or op=0001 (ST).
  - Otherwise go to EXEC, including undefined opcode 0011 and 1111, which execute as no-ops in the datapath.
- MEM:
  - mem_req=1, mem_addr=inst_out[7:0], mem_we=(op==0001), mem_wdata=st_data sampled on DECODE->MEM entry.
  - On mem_ack: for a load, ld_data<=mem_rdata. Go to EXEC.
- EXEC:
  - exec_en=1 for exactly this cycle; retired<=retired+1 (wraps at 65535).
  - Next state: FETCH if run=1, else IDLE.
- Handshake:
  - mem_addr, mem_we and mem_wdata are stable while mem_req=1.
  - mem_req stays high until ack is sampled and drops in the cycle after the ack edge.
  - mem_ack in the same cycle mem_req rises is accepted (zero-wait memory).
  - mem_ack while mem_req=0 is ignored.
- Latency with zero-wait memory:
  - Non-memory instruction: 3 cycles, FETCH->EXEC.
  - LD/ST: 4 cycles.
  - Each memory wait cycle adds 1.
- run deasserted mid-instruction: the current instruction completes through EXEC, then IDLE. No access is abandoned.
- Timeout:
  - Wait counter clears on entry to FETCH/MEM and increments each cycle with mem_req=1 and mem_ack=0.
  - At count=TIMEOUT: go to FAULT, mem_req=0, fault=1.
  - FAULT exits only on reset. pc holds the faulting fetch address +0 (not incremented).
- exec_en is never asserted outside EXEC. inst_out is stable from DECODE through EXEC.

Test Plan:
- Reset then run=1, zero-wait memory, mem[0]=0x4000 (ADD) -> mem_req high, addr 0 at cycle 1; exec_en at cycle 3; pc=1; retired=1.
- mem[1]=0x0010 (LD A,[0x10]), mem[0x10]=0xBEEF -> second access reads addr 0x10, mem_we=0; ld_data=0xBEEF before exec_en; 4-cycle instruction.
- mem[2]=0x1820 (ST B,[0x20]), st_data=0x1234 -> mem_we=1, mem_addr=0x20, mem_wdata=0x1234 held through 3 wait cycles until ack; then exec_en.
- pc_load=1, pc_load_val=0xFF in IDLE, then run, instruction 0x0C05 (LD immediate) -> single fetch at 0xFF, no MEM state, pc wraps to 0x00.
- mem_ack held 0 during FETCH -> fault=1 after TIMEOUT=15 wait cycles, mem_req=0, state stays FAULT until rst_n pulses low; after reset, fault=0 and pc=0.
- run dropped during MEM wait -> access completes, one exec_en, then busy=0. rst_n asserted mid-MEM -> mem_req=0 immediately (asynchronously).
